// File: rtl/sdram_stream_reader.sv
// rtl/sdram_stream_reader.sv - pipelined Wishbone block reader with FWFT return FIFO
// Optional ack timeout/abort: define SDRAM_STREAM_RD_TIMEOUT_EN.
module sdram_stream_reader #(
    parameter int AW          = 32,
    parameter int LEN_W       = 16,
    parameter int FIFO_AW     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_busy,
    output logic             cmd_done,
    output logic             cmd_err,
    output logic [AW-1:0]    wbm_address,
    input  logic [15:0]      wbm_readdata,
    output logic             wbm_strobe,
    output logic             wbm_cycle,
    output logic             wbm_write,
    input  logic             wbm_ack,
    input  logic             wbm_stall,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, DONE} state_t;
    state_t state, state_next;

    logic [AW-1:0]      addr;
    logic [LEN_W-1:0]   reqs_left;
    logic [LEN_W-1:0]   acks_left;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      fifo_count;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [15:0]        mem [DEPTH];
    logic [CW:0]        credit;

    logic start_ok;
    logic issue_ok;
    logic taken;
    logic ack_in;
    logic push;
    logic pop;
    logic abort;

    // Requests in flight plus buffered words never exceed FIFO depth, so every ack has a slot.
    assign credit   = {1'b0, outstanding} + {1'b0, fifo_count};
    assign issue_ok = (state == REQ) && (reqs_left != '0) && (credit < (CW+1)'(DEPTH));
    assign taken    = issue_ok && !wbm_stall;
    assign ack_in   = wbm_ack && wbm_cycle;
    assign push     = ack_in && (fifo_count != CW'(DEPTH));
    assign pop      = out_valid && out_ready;
    assign start_ok = cmd_start && !cmd_busy;

    assign wbm_cycle   = (state == REQ) || (state == WAIT_ACK);
    assign wbm_strobe  = issue_ok;
    assign wbm_address = addr;
    assign wbm_write   = 1'b0;
    assign cmd_busy    = wbm_cycle;
    assign cmd_done    = (state == DONE);
    assign out_valid   = (fifo_count != '0);
    assign out_data    = out_valid ? mem[rd_ptr] : '0;

`ifdef SDRAM_STREAM_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
    logic          to_inc;
    logic          err_q;

    assign to_inc  = wbm_cycle && (outstanding != '0) && !ack_in;
    assign abort   = to_inc && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign cmd_err = err_q;

    always_ff @(posedge clk) begin
        if (reset || !to_inc) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end
`else
    assign abort   = 1'b0;
    assign cmd_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start_ok) begin
                    state_next = (cmd_len == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (abort) begin
                    state_next = DONE;
                end else if (taken && (reqs_left == LEN_W'(1))) begin
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (abort || (ack_in && (acks_left == LEN_W'(1)))) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            reqs_left   <= '0;
            acks_left   <= '0;
            outstanding <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                addr        <= cmd_addr;
                reqs_left   <= cmd_len;
                acks_left   <= cmd_len;
                outstanding <= '0;
            end else if (abort) begin
                reqs_left   <= '0;
                acks_left   <= '0;
                outstanding <= '0;
            end else begin
                if (taken) begin
                    addr      <= addr + AW'(1);
                    reqs_left <= reqs_left - LEN_W'(1);
                end
                if (ack_in && (acks_left != '0)) begin
                    acks_left <= acks_left - LEN_W'(1);
                end
                case ({taken, ack_in && (outstanding != '0)})
                    2'b10:   outstanding <= outstanding + CW'(1);
                    2'b01:   outstanding <= outstanding - CW'(1);
                    default: outstanding <= outstanding;
                endcase
            end
        end
    end

    // Abort flushes the FIFO so a failed block never leaks partial data downstream.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wbm_readdata;
        end
    end
endmodule

// File: tb/tb_sdram_stream_reader.sv
// tb/tb_sdram_stream_reader.sv - self-checking bench: random Wishbone slave model, stream scoreboard
module tb_sdram_stream_reader;
    localparam int AW          = 32;
    localparam int LEN_W       = 16;
    localparam int FIFO_AW     = 4;
    localparam int DEPTH       = 16;
    localparam int TIMEOUT_CYC = 1024;

    logic             clk;
    logic             reset;
    logic             cmd_start;
    logic [AW-1:0]    cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_busy;
    logic             cmd_done;
    logic             cmd_err;
    logic [AW-1:0]    wbm_address;
    logic [15:0]      wbm_readdata;
    logic             wbm_strobe;
    logic             wbm_cycle;
    logic             wbm_write;
    logic             wbm_ack;
    logic             wbm_stall;
    logic [15:0]      out_data;
    logic             out_valid;
    logic             out_ready;

    int     checks = 0;
    int     failures = 0;
    int     stall_pct = 0;
    int     lat_max = 1;
    int     ready_pct = 100;
    int     ack_budget = -1;
    int     taken = 0;
    int     done_cnt = 0;
    int     hold_err = 0;
    int     cycle_seen = 0;
    longint cyc = 0;
    longint last_ack_edge = 0;
    longint done_cyc = 0;
    logic   last_err = 1'b0;
    logic [31:0] taken_addr[$];
    logic [31:0] pend_addr[$];
    longint      pend_due[$];
    logic [15:0] got[$];

    sdram_stream_reader #(
        .AW(AW), .LEN_W(LEN_W), .FIFO_AW(FIFO_AW), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .wbm_address(wbm_address), .wbm_readdata(wbm_readdata), .wbm_strobe(wbm_strobe),
        .wbm_cycle(wbm_cycle), .wbm_write(wbm_write), .wbm_ack(wbm_ack), .wbm_stall(wbm_stall),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[15:0] ^ a[31:16];
    endfunction

    // SDRAM slave: in-order acks with random latency, random stall, plus bus monitor.
    initial begin
        logic        stalled_prev;
        logic [31:0] addr_prev;
        stalled_prev = 1'b0;
        addr_prev    = '0;
        wbm_ack      = 1'b0;
        wbm_stall    = 1'b0;
        wbm_readdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (wbm_cycle) cycle_seen++;
            if (cmd_done) begin
                done_cnt++;
                done_cyc = cyc;
                last_err = cmd_err;
            end
            if (stalled_prev && !reset && (!wbm_strobe || wbm_address !== addr_prev)) hold_err++;
            wbm_ack = 1'b0;
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (wbm_cycle && pend_due.size() > 0 && pend_due[0] <= cyc && ack_budget != 0) begin
                wbm_ack      = 1'b1;
                wbm_readdata = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
                if (ack_budget > 0) ack_budget--;
                last_ack_edge = cyc + 1;
            end
            wbm_stall = ($urandom_range(0, 99) < stall_pct);
            if (!reset && wbm_strobe && !wbm_stall) begin
                taken++;
                taken_addr.push_back(wbm_address);
                pend_addr.push_back(wbm_address);
                pend_due.push_back(cyc + longint'($urandom_range(1, lat_max)));
            end
            stalled_prev = !reset && wbm_strobe && wbm_stall;
            addr_prev    = wbm_address;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (!reset && out_valid && out_ready) got.push_back(out_data);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [31:0] a, input int len);
        taken = 0;
        taken_addr.delete();
        got.delete();
        cmd_addr  = a;
        cmd_len   = LEN_W'(len);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic finish_cmd(input logic [31:0] a, input int len, input int d0, input string tag);
        int n;
        int bad_d;
        int bad_a;
        n = 0;
        while (done_cnt == d0 && n < 20000) begin tick(); n++; end
        chk({tag, "_done_seen"}, done_cnt - d0, 1);
        chk({tag, "_err"}, last_err, 0);
        n = 0;
        while (got.size() < len && n < 20000) begin tick(); n++; end
        repeat (8) tick();
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_words"}, got.size(), len);
        chk({tag, "_strobes"}, taken, len);
        bad_d = 0;
        bad_a = 0;
        for (int i = 0; i < got.size() && i < len; i++)
            if (got[i] !== mem_word(a + 32'(i))) bad_d++;
        for (int i = 0; i < taken_addr.size() && i < len; i++)
            if (taken_addr[i] !== a + 32'(i)) bad_a++;
        chk({tag, "_data_order"}, bad_d, 0);
        chk({tag, "_addr_seq"}, bad_a, 0);
    endtask

    task automatic run_cmd(input logic [31:0] a, input int len, input string tag);
        int d0;
        d0 = done_cnt;
        start_cmd(a, len);
        chk({tag, "_busy"}, cmd_busy, 1);
        finish_cmd(a, len, d0, tag);
    endtask

    initial begin
        int d0;
        int n;
        reset     = 1'b1;
        cmd_start = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        repeat (3) tick();
        chk("rst_busy", cmd_busy, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_cycle", wbm_cycle, 0);
        chk("rst_strobe", wbm_strobe, 0);
        chk("rst_write", wbm_write, 0);
        chk("rst_addr", wbm_address, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b0;
        tick();

        stall_pct = 0; lat_max = 1; ready_pct = 100;
        run_cmd(32'h0000_0100, 16, "basic");

        stall_pct = 50; lat_max = 4;
        run_cmd(32'h0000_0400, 32, "stall");
        chk("stall_hold", hold_err, 0);

        stall_pct = 0; lat_max = 3; ready_pct = 0;
        d0 = done_cnt;
        start_cmd(32'h0000_0800, 40);
        repeat (100) tick();
        chk("bp_taken", taken, DEPTH);
        chk("bp_valid", out_valid, 1);
        chk("bp_strobe", wbm_strobe, 0);
        chk("bp_no_done", done_cnt - d0, 0);
        ready_pct = 100;
        finish_cmd(32'h0000_0800, 40, d0, "bp");

        d0 = done_cnt;
        cycle_seen = 0;
        start_cmd(32'h0000_1234, 0);
        chk("len0_done", cmd_done, 1);
        chk("len0_busy", cmd_busy, 0);
        repeat (5) tick();
        chk("len0_cnt", done_cnt - d0, 1);
        chk("len0_cycle", cycle_seen, 0);
        chk("len0_taken", taken, 0);

        d0 = done_cnt;
        start_cmd(32'h0000_2000, 8);
        repeat (2) tick();
        cmd_addr  = 32'h0000_3000;
        cmd_len   = 16'd5;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        finish_cmd(32'h0000_2000, 8, d0, "busy");

        run_cmd(32'hFFFF_FFFE, 4, "wrap");
        chk("wrap_a2", (taken_addr.size() > 2) ? taken_addr[2] : 32'hDEAD_BEEF, 0);

        for (int k = 0; k < 4; k++) begin
            logic [31:0] ra;
            int          rl;
            ra        = $urandom;
            rl        = $urandom_range(1, 40);
            stall_pct = $urandom_range(0, 60);
            lat_max   = $urandom_range(1, 8);
            ready_pct = $urandom_range(30, 100);
            run_cmd(ra, rl, "rand");
        end
        chk("rand_hold", hold_err, 0);

        stall_pct = 0; lat_max = 2; ready_pct = 100;
        d0 = done_cnt;
        start_cmd(32'h0000_5000, 40);
        repeat (10) tick();
        chk("rstmid_cycle_pre", wbm_cycle, 1);
        reset = 1'b1;
        tick();
        chk("rstmid_cycle", wbm_cycle, 0);
        chk("rstmid_strobe", wbm_strobe, 0);
        chk("rstmid_valid", out_valid, 0);
        reset = 1'b0;
        repeat (20) tick();
        chk("rstmid_no_done", done_cnt - d0, 0);
        chk("rstmid_idle", wbm_cycle, 0);

`ifdef SDRAM_STREAM_RD_TIMEOUT_EN
        stall_pct = 0; lat_max = 1; ready_pct = 0; ack_budget = 3;
        d0 = done_cnt;
        start_cmd(32'h0000_6000, 8);
        n = 0;
        while (done_cnt == d0 && n < 3000) begin tick(); n++; end
        chk("to_done", done_cnt - d0, 1);
        chk("to_err", last_err, 1);
        chk("to_delay", done_cyc - last_ack_edge, TIMEOUT_CYC);
        chk("to_cycle", wbm_cycle, 0);
        chk("to_fifo", out_valid, 0);
        chk("to_words", got.size(), 0);
        ack_budget = -1; ready_pct = 100;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
`else
        n = 0;
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_stream_reader.md
Name: sdram_stream_reader

Overview:
- Pipelined Wishbone master that sits directly upstream of the sdram_top SDRAM Wishbone slave port.
- On a command it reads a block of consecutive 16-bit words from SDRAM and returns them, in order, through a valid/ready stream. Consumers are the synth sample/delay-line engines.
- Honours wbs_sdram_stall and counts acks.
- Keeps outstanding requests bounded by its internal FIFO space, so returned data is never dropped.

Parameters:
- AW, 32, Wishbone address width; matches sdram_top AW_SDRAM.
- LEN_W, 16, width of the command length field.
- FIFO_AW, 4, log2 of the return FIFO depth (default 16 entries).
- TIMEOUT_CYC, 1024, cycles with no ack before the read is aborted (optional feature only).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- cmd_start, input, 1, one-cycle request to start a block read; accepted only when cmd_busy=0.
- cmd_addr, input, AW, first word address; sampled when cmd_start is accepted.
- cmd_len, input, LEN_W, number of words to read; sampled when cmd_start is accepted.
- cmd_busy, output, 1, high from the accepted cmd_start until the cycle of cmd_done.
- cmd_done, output, 1, one-cycle pulse when all words are acked, or on abort.
- cmd_err, output, 1, high with cmd_done if the read was aborted; held until the next accepted cmd_start.
- wbm_address, output, AW, Wishbone address.
- wbm_readdata, input, 16, Wishbone read data.
- wbm_strobe, output, 1, Wishbone strobe.
- wbm_cycle, output, 1, Wishbone cycle.
- wbm_write, output, 1, constant 0.
- wbm_ack, input, 1, Wishbone ack.
- wbm_stall, input, 1, Wishbone pipelined stall.
- out_data, output, 16, stream data (FIFO head).
- out_valid, output, 1, stream valid.
- out_ready, input, 1, stream ready.

Behaviour:
- Reset values: all outputs 0. Reset also clears the FIFO, the counters and the FSM.
- Reset mid-operation: wbm_cycle and wbm_strobe drop in the cycle after reset is sampled. No cmd_done is issued.
- FSM states: IDLE, REQ, WAIT_ACK, DONE.
- IDLE:
  - cmd_start with cmd_len>0 goes to REQ and latches addr, len.
  - cmd_start with cmd_len=0 goes to DONE; there is no bus activity.
  - cmd_busy rises in the cycle after cmd_start.
- REQ:
  - wbm_cycle=1.
  - Issue condition: (reqs_left>0) && (outstanding + fifo_count < 2^FIFO_AW).
  - When issuing, wbm_strobe=1 and wbm_address=current address.
  - A request is taken on a cycle with wbm_strobe && !wbm_stall. On that cycle: address+1 (wraps modulo 2^AW), reqs_left-1, outstanding+1.
  - While wbm_stall=1, strobe and address are held unchanged.
  - If the issue condition fails, strobe=0 and wbm_cycle stays 1.
  - When reqs_left reaches 0, go to WAIT_ACK.
- WAIT_ACK:
  - wbm_strobe=0, wbm_cycle=1.
  - When acks_left reaches 0, go to DONE with wbm_cycle deasserted in the same transition.
- Ack handling (REQ and WAIT_ACK):
  - Each wbm_ack pushes wbm_readdata into the FIFO and decrements outstanding and acks_left.
  - A simultaneous request-taken and ack leaves outstanding unchanged.
  - wbm_ack while wbm_cycle=0 is ignored.
- DONE: one cycle. cmd_done=1, cmd_busy=0, then go to IDLE.
  - FIFO contents remain and may still drain after cmd_done.
- cmd_start while cmd_busy=1 is ignored.
- FIFO:
  - First-word fall-through: out_valid=1 whenever the FIFO is non-empty, and out_data=head.
  - Pop on out_valid && out_ready. Push and pop in the same cycle are both allowed.
  - Overflow is impossible by the credit rule. An ack arriving when full, which can only happen through a protocol violation, is dropped.
- Throughput: with stall=0, ack latency L and out_ready=1, one request is issued per cycle. There are no bubbles while L < FIFO depth.

Optional Feature:
- Macro: SDRAM_STREAM_RD_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each cycle while outstanding>0 and no ack arrives; it clears on any ack.
  - When it reaches TIMEOUT_CYC, the block goes to DONE with cmd_err=1. wbm_cycle and wbm_strobe drop immediately, and the FIFO is flushed.
- Without the macro: no counter exists, cmd_err is tied to 0, and the block waits indefinitely for acks.

Test Plan:
- Basic read: preload SDRAM 0x100..0x10F with data=addr; cmd_addr=0x100, cmd_len=16, out_ready=1, stall=0 -> out_data 0x0100..0x010F in order; exactly 16 strobes taken; one cmd_done; cmd_err=0.
- Stall: random wbm_stall ~50%, len=32 from 0x400 -> address is held stable during stall; 32 words in order with no duplicates or skips.
- Backpressure: out_ready=0, len=40 -> at most 16 outstanding+buffered; strobe stops; out_ready then goes 1 -> all 40 delivered in order.
- len=0 and busy: cmd_len=0 -> cmd_done in 2 cycles with no wbm_cycle. A second cmd_start issued while busy -> ignored, with only one cmd_done.
- Wrap and reset: cmd_addr=0xFFFF_FFFE, len=4 -> addresses FFFFFFFE, FFFFFFFF, 0, 1. Reset asserted mid-transfer -> wbm_cycle=0 the next cycle, out_valid=0, no cmd_done.
- Timeout (macro on, TIMEOUT_CYC=1024): slave acks 3 of 8 reads, then stops acking -> cmd_done with cmd_err=1 exactly 1024 cycles after the last ack; wbm_cycle=0 and FIFO empty.
